dht11_poll_scheduler: RTL
=========================

Name:
dht11_poll_scheduler

Overview:
- Sequences the DHT11 acquisition engine: waits out sensor power-up, triggers reads periodically or on demand, and enforces a minimum gap between reads.
- Supervises each read with a timeout, verifies the checksum and retries failed reads.
- Publishes validated humidity/temperature words over a valid/ready interface to the IoT uplink logic.
- Sits between the DHT11 reader (40-bit frame variant with start/error) and the UART/telemetry packetiser.

Parameters:
- CYCLES_PER_MS, 12000, clk cycles per 1 ms tick (12 MHz); the bench overrides it small.
- POWERUP_MS, 1000, wait after reset before the first trigger.
- PERIOD_MS, 2000, interval between scheduled acquisitions.
- MIN_GAP_MS, 1000, minimum time from one rd_start to the next (any cause).
- TIMEOUT_MS, 30, maximum time from rd_start to rd_done/rd_error.
- RETRY_MS, 1000, backoff before a retry.
- MAX_TRIES, 3, attempts per acquisition (first try included).

Ports:
- clk  in  1  system clock, 12 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scheduled/on-demand acquisition permitted.
- req_now  in  1  single-cycle on-demand read request.
- rd_start  out  1  single-cycle trigger to the reader.
- rd_done  in  1  single-cycle pulse: frame valid on rd_data.
- rd_error  in  1  single-cycle pulse: reader protocol error.
- rd_data  in  40  {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first.
- out_valid  out  1  sample available.
- out_ready  in  1  downstream accept.
- out_hum  out  16  {hum_int, hum_dec}.
- out_temp  out  16  {temp_int, temp_dec}.
- fault  out  1  sticky: last acquisition exhausted MAX_TRIES.
- err_count  out  8  saturating count of failed attempts.
- sample_count  out  16  wrapping count of accepted samples.

Behaviour:
- Reset is asynchronous; clk and reset_n are already decided as stated in Ports. All outputs reset to 0. State resets to S_POWERUP and all timers clear.
- ms tick: a free-running prescaler pulses once every CYCLES_PER_MS cycles. All *_MS timers count ticks, so resolution is +0/-1 ms.
- gap timer: cleared on every rd_start and saturates at MIN_GAP_MS. "gap_ok" means gap timer == MIN_GAP_MS. The gap timer is treated as satisfied after power-up.
- S_POWERUP: after POWERUP_MS ticks -> S_IDLE with the period timer expired.
- S_IDLE: the period timer counts. Go to S_TRIGGER when enable && gap_ok && (period expired || req_now seen).
  - req_now is latched as pending if it arrives while gap_ok is false or in any non-IDLE state. The pending flag clears on the next rd_start.
  - With enable low, stay in S_IDLE; pending requests are held.
- S_TRIGGER: assert rd_start for exactly one cycle, clear the timeout timer, increment the try counter -> S_WAIT.
- S_WAIT:
  - rd_error, or timeout timer reaching TIMEOUT_MS -> FAIL.
  - rd_done -> capture rd_data, go to S_CHECK.
  - rd_done and rd_error in the same cycle: the error wins.
- S_CHECK (1 cycle): pass if checksum == (b4+b3+b2+b1) mod 256.
  - pass -> load out_hum/out_temp, go to S_PUBLISH; out_valid rises on the cycle after S_CHECK.
  - fail -> FAIL.
- FAIL:
  - err_count +1, saturating at 255.
  - If tries < MAX_TRIES -> S_BACKOFF, wait RETRY_MS (also wait until gap_ok) -> S_TRIGGER.
  - Otherwise set fault, reset tries, restart the period timer, go to S_IDLE.
- S_PUBLISH: hold out_valid with data stable until out_ready is sampled high.
  - On that cycle: out_valid -> 0, sample_count +1 (wraps at 16 bits), clear fault, reset tries, restart the period timer, go to S_IDLE.
  - No new trigger occurs while out_valid is high (backpressure stalls scheduling).
- rd_done/rd_error outside S_WAIT are ignored.
- enable falling mid-acquisition does not abort; the current attempt and its retries complete.
- Reset mid-operation: immediate return to reset values. A reader still busy is ignored until its next rd_start.

Test Plan:
- CYCLES_PER_MS=10, POWERUP_MS=5, PERIOD_MS=20, MIN_GAP_MS=10, TIMEOUT_MS=3, RETRY_MS=4, MAX_TRIES=3. Release reset, enable=1 -> first rd_start at cycle 50±10. Reply rd_done with rd_data=40'h3500_1800_4D -> out_valid two cycles later, out_hum=16'h3500, out_temp=16'h1800. Hold out_ready low 7 cycles: data stable, no rd_start. Pulse out_ready -> sample_count=1.
- Reply with rd_data=40'h3500_1800_4E (bad checksum) three times -> err_count=3, fault=1, three rd_starts spaced ≥40 cycles. A later good read -> fault=0.
- Never answer rd_start -> rd_error-equivalent timeout after 30±10 cycles per try; the retry sequence matches the previous scenario.
- req_now 30 cycles after an accepted sample (gap timer ≥10 ms) -> rd_start within 2 cycles. req_now 3 ms after rd_start -> deferred until 10 ms after that rd_start.
- rd_done and rd_error in the same cycle -> counted as a failure; no out_valid.
- Assert reset_n=0 during S_WAIT and S_PUBLISH -> all outputs 0 immediately; the power-up wait restarts.

Source files
------------

// File: rtl/dht11_poll_scheduler_if.sv
// Reader trigger/response bus and validated-sample valid/ready stream of the DHT11 scheduler.
interface dht11_poll_scheduler_if;
    logic        rd_start;
    logic        rd_done;
    logic        rd_error;
    logic [39:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_hum;
    logic [15:0] out_temp;

    modport master (
        output rd_start,
        input  rd_done,
        input  rd_error,
        input  rd_data,
        output out_valid,
        output out_hum,
        output out_temp,
        input  out_ready
    );

    modport slave (
        input  rd_start,
        output rd_done,
        output rd_error,
        output rd_data,
        input  out_valid,
        input  out_hum,
        input  out_temp,
        output out_ready
    );
endinterface

// File: rtl/dht11_poll_scheduler.sv
// DHT11 acquisition scheduler: power-up wait, periodic/on-demand triggers with a minimum read gap,
// per-read timeout, checksum check with retries, and valid/ready publishing of the samples.
module dht11_poll_scheduler #(
    parameter int CYCLES_PER_MS = 12000,
    parameter int POWERUP_MS    = 1000,
    parameter int PERIOD_MS     = 2000,
    parameter int MIN_GAP_MS    = 1000,
    parameter int TIMEOUT_MS    = 30,
    parameter int RETRY_MS      = 1000,
    parameter int MAX_TRIES     = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   req_now,
    dht11_poll_scheduler_if.master bus,
    output logic                   fault,
    output logic [7:0]             err_count,
    output logic [15:0]            sample_count
);
    localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam int TW = 16;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_IDLE,
        S_TRIGGER,
        S_WAIT,
        S_CHECK,
        S_FAIL,
        S_BACKOFF,
        S_PUBLISH
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   presc;
    logic            tick;
    logic [TW-1:0]   state_ms;
    logic [TW-1:0]   gap_ms;
    logic [TW-1:0]   period_ms;
    logic            gap_ok;
    logic            period_done;
    logic            pending;
    logic [39:0]     frame;
    logic [7:0]      csum;
    logic            csum_ok;
    logic [7:0]      tries;
    logic            retry_left;
    logic            powerup_done;
    logic            period_restart;

    assign tick        = (presc == PW'(CYCLES_PER_MS - 1));
    assign gap_ok      = (gap_ms == TW'(MIN_GAP_MS));
    assign period_done = (period_ms == TW'(PERIOD_MS));
    assign csum        = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    assign csum_ok     = (csum == frame[7:0]);
    assign retry_left  = (tries < 8'(MAX_TRIES));

    assign powerup_done   = (state == S_POWERUP) && (state_next == S_IDLE);
    assign period_restart = ((state == S_PUBLISH) && bus.out_ready) ||
                            ((state == S_FAIL) && !retry_left);

    assign bus.rd_start  = (state == S_TRIGGER);
    assign bus.out_valid = (state == S_PUBLISH);

    // State register; state_ms counts ms ticks since entering the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_POWERUP;
            state_ms <= '0;
        end else begin
            state <= state_next;
            if (state != state_next)
                state_ms <= '0;
            else if (tick && (state_ms != '1))
                state_ms <= state_ms + 1'b1;
        end
    end

    // Error beats done in the same cycle; the gap must also be met before a retry.
    always_comb begin
        state_next = state;
        case (state)
            S_POWERUP: if (tick && (state_ms == TW'(POWERUP_MS - 1))) state_next = S_IDLE;
            S_IDLE:    if (enable && gap_ok && (period_done || req_now || pending))
                           state_next = S_TRIGGER;
            S_TRIGGER: state_next = S_WAIT;
            S_WAIT: begin
                if (bus.rd_error || (tick && (state_ms == TW'(TIMEOUT_MS - 1))))
                    state_next = S_FAIL;
                else if (bus.rd_done)
                    state_next = S_CHECK;
            end
            S_CHECK:   state_next = csum_ok ? S_PUBLISH : S_FAIL;
            S_FAIL:    state_next = retry_left ? S_BACKOFF : S_IDLE;
            S_BACKOFF: if ((state_ms >= TW'(RETRY_MS)) && gap_ok) state_next = S_TRIGGER;
            S_PUBLISH: if (bus.out_ready) state_next = S_IDLE;
            default:   state_next = S_POWERUP;
        endcase
    end

    // The gap counts as satisfied and the period as expired once power-up is over.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc     <= '0;
            gap_ms    <= '0;
            period_ms <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;

            if (bus.rd_start)
                gap_ms <= '0;
            else if (powerup_done)
                gap_ms <= TW'(MIN_GAP_MS);
            else if (tick && !gap_ok)
                gap_ms <= gap_ms + 1'b1;

            if (powerup_done)
                period_ms <= TW'(PERIOD_MS);
            else if (period_restart)
                period_ms <= '0;
            else if ((state == S_IDLE) && tick && !period_done)
                period_ms <= period_ms + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame        <= '0;
            bus.out_hum  <= '0;
            bus.out_temp <= '0;
            tries        <= '0;
            fault        <= 1'b0;
            err_count    <= '0;
            sample_count <= '0;
            pending      <= 1'b0;
        end else begin
            if ((state == S_WAIT) && (state_next == S_CHECK))
                frame <= bus.rd_data;

            if ((state == S_CHECK) && csum_ok) begin
                bus.out_hum  <= frame[39:24];
                bus.out_temp <= frame[23:8];
            end

            if (state == S_TRIGGER)
                tries <= tries + 1'b1;

            if (state == S_FAIL) begin
                if (err_count != 8'hFF)
                    err_count <= err_count + 1'b1;
                if (!retry_left) begin
                    fault <= 1'b1;
                    tries <= '0;
                end
            end

            if ((state == S_PUBLISH) && bus.out_ready) begin
                sample_count <= sample_count + 1'b1;
                fault        <= 1'b0;
                tries        <= '0;
            end

            // A request is only forgotten once a read actually starts.
            if (req_now)
                pending <= 1'b1;
            else if (bus.rd_start)
                pending <= 1'b0;
        end
    end
endmodule
